// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Avalon-MM read master feeding the SRAM slave bridge with sequential word
//   reads. A transfer fetches `length` words starting at `base_addr`, buffers
//   them in a first-word-fall-through FIFO and streams them out in address order.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle request, sampled only while idle
//   base_addr, length    transfer parameters, latched on an accepted start
//   busy                 high whenever the FSM is not idle
//   done                 one-cycle pulse when a transfer completes
//   m_chipselect_n, m_read_n, m_write_n, m_byteenable_n, m_address, m_readdata
//                        registered Avalon-MM master bus toward the SRAM bridge
//   st_data, st_valid, st_ready
//                        stream source toward the consumer
//   dbg_state            current FSM state for observation
//
// Stream handshake: a word transfers on every rising clk edge where st_valid
// and st_ready are both high; st_data is stable while st_valid is high and
// st_ready is low, and st_valid never drops without a transfer.
module sram_stream_reader #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              m_chipselect_n,
    output logic              m_read_n,
    output logic              m_write_n,
    output logic [1:0]        m_byteenable_n,
    output logic [ADDR_W-1:0] m_address,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       WAIT_C  = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [2:0]        wait_q, wait_d;
    logic              done_q, done_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] m_address_q;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic              space_now;
    logic              space_after_push;

    assign st_valid  = (count_q != '0);
    assign pop       = st_valid && st_ready;
    // Masked so the head reads as zero while empty (including after reset).
    assign st_data   = st_valid ? mem_q[rd_ptr_q] : '0;
    assign space_now = (count_q < DEPTH_C);
    // A pop on the same edge frees the slot this push consumes.
    assign space_after_push = pop || (count_q < (DEPTH_C - CNT_W'(1)));

    // Next-state and transfer bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        done_d      = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d      = base_addr;
                        remaining_d = length;
                        wait_d      = '0;
                        state_d     = space_now ? READ : HOLD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (wait_q == WAIT_C) begin
                    push        = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    wait_d      = '0;
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = DRAIN;
                    end else if (space_after_push) begin
                        state_d = READ;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            HOLD: begin
                if (space_now) begin
                    wait_d  = '0;
                    state_d = READ;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they line up with READ.
    assign strobe_d = (state_d == READ);

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            strobe_q    <= 1'b0;
            m_address_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            done_q      <= done_d;
            strobe_q    <= strobe_d;
            m_address_q <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= m_readdata;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign m_chipselect_n = ~strobe_q;
    assign m_read_n       = ~strobe_q;
    assign m_write_n      = 1'b1;
    assign m_byteenable_n = strobe_q ? 2'b00 : 2'b11;
    assign m_address      = m_address_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int WAIT   = 1;
    localparam int DEPTH  = 16;
    localparam int WPW    = WAIT + 1;   // bus cycles per word

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic              m_chipselect_n;
    logic              m_read_n;
    logic              m_write_n;
    logic [1:0]        m_byteenable_n;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    logic [ADDR_W-1:0] bus_log[$];
    int rd_cycles = 0;
    int run       = 0;
    int max_run   = 0;
    int done_cnt  = 0;

    sram_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done),
        .m_chipselect_n(m_chipselect_n), .m_read_n(m_read_n),
        .m_write_n(m_write_n), .m_byteenable_n(m_byteenable_n),
        .m_address(m_address), .m_readdata(m_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .dbg_state(dbg_state)
    );

    // Slave model: each address reads back as its low half XOR A5A5.
    assign m_readdata = m_address[DATA_W-1:0] ^ 16'hA5A5;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        got_q.delete();
        bus_log.delete();
        rd_cycles = 0;
        run       = 0;
        max_run   = 0;
        done_cnt  = 0;
    endtask

    // Issues a start and loads the model with the words the transfer must yield.
    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + ADDR_W'(i);
            exp_q.push_back(a[DATA_W-1:0] ^ 16'hA5A5);
        end
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Compare process: bus invariants, bus log, and stream order vs model.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("write_n_const", 32'(m_write_n), 32'd1);
            if (m_read_n === 1'b0) begin
                rd_cycles++;
                run++;
                if (run > max_run) max_run = run;
                bus_log.push_back(m_address);
                check("cs_during_read", 32'(m_chipselect_n), 32'd0);
                check("be_during_read", 32'(m_byteenable_n), 32'd0);
            end else begin
                run = 0;
                check("cs_idle", 32'(m_chipselect_n), 32'd1);
                check("be_idle", 32'(m_byteenable_n), 32'd3);
            end
            if (done === 1'b1) done_cnt++;
            if (st_valid === 1'b1 && st_ready === 1'b1) begin
                got_q.push_back(st_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(st_data), 32'hFFFF_FFFF);
                end else begin
                    check("stream_word", 32'(st_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic check_bus_addrs(input logic [ADDR_W-1:0] b, input int n, input string name);
        logic [ADDR_W-1:0] a;
        check({name, "_len"}, 32'(bus_log.size()), 32'(n * WPW));
        for (int i = 0; i < n; i++) begin
            a = b + ADDR_W'(i);
            for (int k = 0; k < WPW; k++) begin
                if (i * WPW + k < bus_log.size())
                    check(name, 32'(bus_log[i * WPW + k]), 32'(a));
            end
        end
    endtask

    initial begin
        bit seen;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        st_ready  = 1'b0;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(st_valid), 32'd0);
        check("rst_data", 32'(st_data), 32'd0);
        check("rst_addr", 32'(m_address), 32'd0);
        check("rst_read_n", 32'(m_read_n), 32'd1);
        check("rst_cs_n", 32'(m_chipselect_n), 32'd1);
        check("rst_be_n", 32'(m_byteenable_n), 32'd3);
        check("rst_write_n", 32'(m_write_n), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_read_n", 32'(m_read_n), 32'd1);
        check("post_rst_valid", 32'(st_valid), 32'd0);

        // 2. four words from 0x00010, consumer always ready
        clear_stats();
        st_ready = 1'b1;
        do_start(20'h00010, 20'd4);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_read_n", 32'(m_read_n), 32'd0);
        check("t2_first_addr", 32'(m_address), 32'h00010);
        wait_done(100, "t2_done_seen");
        check("t2_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("t2_w0", 32'(got_q[0]), 32'hA5B5);
            check("t2_w1", 32'(got_q[1]), 32'hA5B4);
            check("t2_w2", 32'(got_q[2]), 32'hA5B7);
            check("t2_w3", 32'(got_q[3]), 32'hA5B6);
        end
        check("t2_read_cycles", 32'(rd_cycles), 32'd8);
        check("t2_read_run", 32'(max_run), 32'd8);
        check("t2_done_pulses", 32'(done_cnt), 32'd1);
        check("t2_busy_end", 32'(busy), 32'd0);
        check_bus_addrs(20'h00010, 4, "t2_bus_addr");

        // 3. twenty words with the consumer stalled, then released
        clear_stats();
        st_ready = 1'b0;
        do_start(20'h00100, 20'd20);
        repeat (60) @(negedge clk);
        check("t3_stall_read_cycles", 32'(rd_cycles), 32'(DEPTH * WPW));
        check("t3_stall_read_n", 32'(m_read_n), 32'd1);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_valid", 32'(st_valid), 32'd1);
        check("t3_stall_head", 32'(st_data), 32'hA4A5);
        check("t3_stall_none_out", 32'(got_q.size()), 32'd0);
        @(posedge clk);
        #1;
        st_ready = 1'b1;
        wait_done(300, "t3_done_seen");
        check("t3_count", 32'(got_q.size()), 32'd20);
        check("t3_read_cycles", 32'(rd_cycles), 32'(20 * WPW));
        check("t3_done_pulses", 32'(done_cnt), 32'd1);
        check("t3_model_empty", 32'(exp_q.size()), 32'd0);
        check_bus_addrs(20'h00100, 20, "t3_bus_addr");

        // 4. address wrap at the top of the space
        clear_stats();
        do_start(20'hFFFFE, 20'd4);
        wait_done(100, "t4_done_seen");
        check_bus_addrs(20'hFFFFE, 4, "t4_bus_addr");
        if (bus_log.size() == 4 * WPW) begin
            check("t4_addr2", 32'(bus_log[2 * WPW]), 32'h00000);
            check("t4_addr3", 32'(bus_log[3 * WPW]), 32'h00001);
        end
        check("t4_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) check("t4_w0", 32'(got_q[0]), 32'h5A5B);

        // 5. zero-length request
        clear_stats();
        do_start(20'h00055, 20'd0);
        @(negedge clk);
        check("t5_done_now", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t5_done_gone", 32'(done), 32'd0);
        check("t5_busy2", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_read_cycles", 32'(rd_cycles), 32'd0);
        check("t5_done_pulses", 32'(done_cnt), 32'd1);

        // 6. reset during the third word, then a fresh two-word transfer
        clear_stats();
        st_ready = 1'b0;
        do_start(20'h00020, 20'd8);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (bus_log.size() >= 2 * WPW + 1) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_third_word_seen", 32'(seen), 32'd1);
        check("t6_valid_before", 32'(st_valid), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_rst_read_n", 32'(m_read_n), 32'd1);
        check("t6_rst_cs_n", 32'(m_chipselect_n), 32'd1);
        check("t6_rst_be_n", 32'(m_byteenable_n), 32'd3);
        check("t6_rst_valid", 32'(st_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_stats();
        st_ready = 1'b1;
        do_start(20'h00000, 20'd2);
        wait_done(100, "t6_done_seen");
        check("t6_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t6_w0", 32'(got_q[0]), 32'hA5A5);
            check("t6_w1", 32'(got_q[1]), 32'hA5A4);
        end
        check("t6_read_cycles", 32'(rd_cycles), 32'(2 * WPW));
        check("t6_model_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
